// File: rtl/cpu_mode_loader.sv
// Front-panel program loader: selects CPU mode, writes switch bytes into
// memory in IN mode and reads them back in CHECK mode, one access per step press.
module cpu_mode_loader (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mode_req,
   input  logic        step,
   input  logic [7:0]  sw_data,
   input  logic [7:0]  mem_dout,
   output logic [1:0]  cpustate,
   output logic [15:0] ld_addr,
   output logic [7:0]  ld_data,
   output logic        mem_we,
   output logic        mem_re,
   output logic [7:0]  check_data,
   output logic        busy
);

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned MODE_W = 2;

   localparam logic [MODE_W-1:0] MODE_IDLE  = 2'b00;
   localparam logic [MODE_W-1:0] MODE_IN    = 2'b01;
   localparam logic [MODE_W-1:0] MODE_CHECK = 2'b10;
   localparam logic [MODE_W-1:0] MODE_RUN   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_IN_WAIT,
      S_IN_WR,
      S_CHK_WAIT,
      S_CHK_RD,
      S_CHK_CAP,
      S_RUN
   } state_t;

   state_t              state, state_next;
   logic                step_q;
   logic                step_rise;
   logic                mode_change;
   logic [ADDR_W-1:0]   addr_next;
   logic [DATA_W-1:0]   data_next;
   logic [DATA_W-1:0]   chk_next;
   logic [MODE_W-1:0]   cpustate_next;

   // Resting state a requested mode lands in.
   function automatic state_t mode_entry(input logic [MODE_W-1:0] mode);
      state_t s;
      unique case (mode)
         MODE_IN:    s = S_IN_WAIT;
         MODE_CHECK: s = S_CHK_WAIT;
         MODE_RUN:   s = S_RUN;
         default:    s = S_IDLE;
      endcase
      return s;
   endfunction

   function automatic logic [MODE_W-1:0] state_mode(input state_t s);
      logic [MODE_W-1:0] m;
      unique case (s)
         S_IN_WAIT, S_IN_WR:             m = MODE_IN;
         S_CHK_WAIT, S_CHK_RD, S_CHK_CAP: m = MODE_CHECK;
         S_RUN:                          m = MODE_RUN;
         default:                        m = MODE_IDLE;
      endcase
      return m;
   endfunction

   assign step_rise   = step & ~step_q;
   assign mode_change = (mode_req != cpustate);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         step_q <= 1'b0;
      end else begin
         state  <= state_next;
         step_q <= step;
      end
   end

   // Next state and next values of the registered outputs.
   always_comb begin
      state_next = state;
      addr_next  = ld_addr;
      data_next  = ld_data;
      chk_next   = check_data;

      unique case (state)
         S_IDLE, S_RUN: begin
            if (mode_change) state_next = mode_entry(mode_req);
         end
         S_IN_WAIT: begin
            if (mode_change) begin
               state_next = mode_entry(mode_req);
            end else if (step_rise) begin
               data_next  = sw_data;
               state_next = S_IN_WR;
            end
         end
         S_IN_WR: begin
            addr_next  = ld_addr + ADDR_W'(1);
            state_next = S_IN_WAIT;
         end
         S_CHK_WAIT: begin
            if (mode_change) state_next = mode_entry(mode_req);
            else if (step_rise) state_next = S_CHK_RD;
         end
         S_CHK_RD: begin
            state_next = S_CHK_CAP;
         end
         S_CHK_CAP: begin
            chk_next   = mem_dout;
            addr_next  = ld_addr + ADDR_W'(1);
            state_next = S_CHK_WAIT;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Only a real mode change reaches a wait state from a resting state.
      if ((state == S_IDLE || state == S_RUN || state == S_IN_WAIT || state == S_CHK_WAIT) &&
          mode_change && (mode_req == MODE_IN || mode_req == MODE_CHECK))
         addr_next = '0;

      cpustate_next = state_mode(state_next);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpustate   <= MODE_IDLE;
         ld_addr    <= '0;
         ld_data    <= '0;
         check_data <= '0;
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         cpustate   <= cpustate_next;
         ld_addr    <= addr_next;
         ld_data    <= data_next;
         check_data <= chk_next;
         mem_we     <= (state_next == S_IN_WR);
         mem_re     <= (state_next == S_CHK_RD);
         busy       <= (state_next == S_IN_WR) || (state_next == S_CHK_RD) ||
                       (state_next == S_CHK_CAP);
      end
   end

endmodule

// File: tb/tb_cpu_mode_loader.sv
// Randomized and directed bench for cpu_mode_loader against a transaction-level
// model of the loader (mode, pending access, address, memory image).
module tb_cpu_mode_loader;

   logic        clk;
   logic        rst;
   logic [1:0]  mode_req;
   logic        step;
   logic [7:0]  sw_data;
   logic [7:0]  mem_dout;
   logic [1:0]  cpustate;
   logic [15:0] ld_addr;
   logic [7:0]  ld_data;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  check_data;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   cpu_mode_loader dut (
      .clk        (clk),
      .rst        (rst),
      .mode_req   (mode_req),
      .step       (step),
      .sw_data    (sw_data),
      .mem_dout   (mem_dout),
      .cpustate   (cpustate),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .check_data (check_data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Memory seen by the DUT's strobes.
   byte unsigned env_mem [int];
   always @(posedge clk) begin
      if (mem_we) env_mem[int'(ld_addr)] = ld_data;
      if (mem_re) mem_dout <= env_mem.exists(int'(ld_addr)) ? env_mem[int'(ld_addr)] : 8'h00;
   end

   // Reference model: current mode, cycles left in the pending access, own memory image.
   // pend: 0 none, 1 write cycle, 2 read strobe cycle, 3 capture cycle.
   int          m_mode = 0;
   int          m_pend = 0;
   logic [15:0] m_addr = 16'h0;
   logic [7:0]  m_data = 8'h0;
   logic [7:0]  m_chk  = 8'h0;
   logic        m_stepq = 1'b0;
   byte unsigned m_mem [int];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode = 0; m_pend = 0; m_addr = 16'h0; m_data = 8'h0; m_chk = 8'h0; m_stepq = 1'b0;
      end else begin
         if (m_pend == 1) begin
            m_mem[int'(m_addr)] = m_data;
            m_addr = m_addr + 16'd1;
            m_pend = 0;
         end else if (m_pend == 2) begin
            m_pend = 3;
         end else if (m_pend == 3) begin
            m_chk  = m_mem.exists(int'(m_addr)) ? m_mem[int'(m_addr)] : 8'h00;
            m_addr = m_addr + 16'd1;
            m_pend = 0;
         end else if (int'(mode_req) != m_mode) begin
            if (mode_req == 2'd1 || mode_req == 2'd2) m_addr = 16'h0;
            m_mode = int'(mode_req);
         end else if (step && !m_stepq) begin
            if (m_mode == 1) begin
               m_data = sw_data;
               m_pend = 1;
            end else if (m_mode == 2) begin
               m_pend = 2;
            end
         end
         m_stepq = step;
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("cpustate", 32'(cpustate), 32'(m_mode));
      chk("ld_addr", 32'(ld_addr), 32'(m_addr));
      chk("ld_data", 32'(ld_data), 32'(m_data));
      chk("check_data", 32'(check_data), 32'(m_chk));
      chk("mem_we", 32'(mem_we), 32'(m_pend == 1));
      chk("mem_re", 32'(mem_re), 32'(m_pend == 2));
      chk("busy", 32'(busy), 32'(m_pend != 0));
      chk("we_re_excl", 32'(mem_we & mem_re), 32'd0);
   end

   int cnt;
   int guard;

   initial begin
      rst = 1'b0; mode_req = 2'd0; step = 1'b0; sw_data = 8'h00; mem_dout = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_cpustate", 32'(cpustate), 32'd0);
      chk("rst_addr", 32'(ld_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      #2 rst = 1'b1;

      // Load two bytes.
      @(negedge clk); mode_req = 2'd1;
      @(negedge clk); sw_data = 8'h15; step = 1'b1;
      @(negedge clk); step = 1'b0;
      chk("load0_we", 32'(mem_we), 32'd1);
      chk("load0_addr", 32'(ld_addr), 32'h0000);
      chk("load0_data", 32'(ld_data), 32'h15);
      @(negedge clk); sw_data = 8'h2C; step = 1'b1;
      @(negedge clk); step = 1'b0;
      chk("load1_we", 32'(mem_we), 32'd1);
      chk("load1_addr", 32'(ld_addr), 32'h0001);
      chk("load1_data", 32'(ld_data), 32'h2C);
      @(negedge clk);
      chk("load_end_addr", 32'(ld_addr), 32'h0002);
      chk("mem0", 32'(env_mem[0]), 32'h15);
      chk("mem1", 32'(env_mem[1]), 32'h2C);

      // Read back address 0.
      mode_req = 2'd2;
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      chk("chk_re", 32'(mem_re), 32'd1);
      chk("chk_re_addr", 32'(ld_addr), 32'h0000);
      @(negedge clk);
      @(negedge clk);
      chk("chk_data", 32'(check_data), 32'h15);
      chk("chk_addr", 32'(ld_addr), 32'h0001);

      // Held step gives one write.
      mode_req = 2'd1;
      @(negedge clk); step = 1'b1; cnt = 0;
      repeat (20) begin @(negedge clk); cnt += int'(mem_we); end
      step = 1'b0;
      repeat (2) begin @(negedge clk); cnt += int'(mem_we); end
      chk("held_step_writes", 32'(cnt), 32'd1);

      // Mode change during the write is deferred.
      step = 1'b1;
      @(negedge clk); step = 1'b0; mode_req = 2'd3;
      chk("defer_we", 32'(mem_we), 32'd1);
      @(negedge clk);
      chk("defer_we_off", 32'(mem_we), 32'd0);
      chk("defer_mode_in", 32'(cpustate), 32'd1);
      @(negedge clk);
      chk("defer_run", 32'(cpustate), 32'd3);
      step = 1'b1;
      @(negedge clk); step = 1'b0;
      chk("run_no_we", 32'(mem_we), 32'd0);

      // Address wrap.
      mode_req = 2'd1;
      @(negedge clk);
      #2 force dut.ld_addr = 16'hFFFF;
      m_addr = 16'hFFFF;
      #1 release dut.ld_addr;
      @(negedge clk); sw_data = 8'hA5; step = 1'b1;
      @(negedge clk); step = 1'b0;
      chk("wrap_we", 32'(mem_we), 32'd1);
      chk("wrap_addr", 32'(ld_addr), 32'hFFFF);
      @(negedge clk);
      chk("wrap_after", 32'(ld_addr), 32'h0000);

      // Reset in the middle of a read strobe.
      mode_req = 2'd2;
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      chk("mid_re", 32'(mem_re), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("async_re", 32'(mem_re), 32'd0);
      chk("async_we", 32'(mem_we), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_cpustate", 32'(cpustate), 32'd0);
      chk("async_addr", 32'(ld_addr), 32'd0);
      chk("async_data", 32'(ld_data), 32'd0);
      chk("async_chk", 32'(check_data), 32'd0);
      @(negedge clk); #2 rst = 1'b1;

      // Bounded wait for any access to prove the block restarts after reset.
      mode_req = 2'd1;
      @(negedge clk); #1 step = 1'b1; sw_data = 8'h3C;
      guard = 0;
      while (!mem_we && guard < 10) begin @(negedge clk); guard++; end
      chk("restart_we", 32'(mem_we), 32'd1);
      #1 step = 1'b0;

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         #1;
         if ($urandom_range(0, 9) == 0) mode_req = 2'($urandom_range(0, 3));
         step    = ($urandom_range(0, 2) == 0);
         sw_data = 8'($urandom);
         if ($urandom_range(0, 199) == 0) rst = 1'b0;
         else rst = 1'b1;
      end
      #1 rst = 1'b1;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_mode_loader.md
CPU_MODE_LOADER -- requirements
Module: cpu_mode_loader

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, rst.
REQ-002 Ports SHALL be:
- clk  in  1  system clock, rising edge active
- rst  in  1  asynchronous active-low reset
- mode_req  in  2  requested mode: 00 IDLE, 01 IN, 10 CHECK, 11 RUN
- step  in  1  debounced, clk-synchronous load/check button level
- sw_data  in  8  byte to be written in IN mode
- mem_dout  in  8  memory read data, valid the cycle after mem_re
- cpustate  out  2  current mode, same encoding as mode_req; drives the control unit and datapath
- ld_addr  out  16  loader memory address
- ld_data  out  8  loader write data
- mem_we  out  1  one-cycle memory write strobe
- mem_re  out  1  one-cycle memory read strobe
- check_data  out  8  last byte read back in CHECK mode
- busy  out  1  high while a write, read or capture is in flight

Function
REQ-003 The FSM SHALL have exactly these states: S_IDLE, S_IN_WAIT, S_IN_WR, S_CHK_WAIT, S_CHK_RD, S_CHK_CAP and S_RUN.
REQ-004 cpustate SHALL be 00 in S_IDLE, 01 in S_IN_*, 10 in S_CHK_*, and 11 in S_RUN; it SHALL be a registered output.
REQ-005 Step edge: the block SHALL register step into step_q; step_rise = step & ~step_q; a held step SHALL produce one access only.
REQ-006 Mode changes SHALL be accepted only in S_IDLE, S_IN_WAIT, S_CHK_WAIT and S_RUN. If mode_req differs from cpustate in one of those states, the FSM SHALL enter the requested mode's idle/wait state (or S_RUN) on the next edge.
REQ-007 Entering S_IN_WAIT or S_CHK_WAIT from any other mode SHALL clear ld_addr to 0x0000 on the same edge.
REQ-008 S_IN_WAIT: on step_rise with no mode change, the FSM SHALL latch sw_data into ld_data and enter S_IN_WR.
REQ-009 S_IN_WR SHALL last one cycle with mem_we=1, ld_addr and ld_data stable. It SHALL then return to S_IN_WAIT, and ld_addr SHALL increment by 1 on that edge.
REQ-010 S_CHK_WAIT: on step_rise, the FSM SHALL enter S_CHK_RD.
REQ-011 S_CHK_RD SHALL last one cycle with mem_re=1. It SHALL be followed by S_CHK_CAP, where check_data <= mem_dout at the end of S_CHK_CAP. ld_addr SHALL increment by 1 on the same edge, and the FSM SHALL return to S_CHK_WAIT.
REQ-012 Latency step_rise-cycle to mem_we: 1 cycle. Latency step_rise-cycle to check_data update: 3 cycles.
REQ-013 ld_addr SHALL wrap from 0xFFFF to 0x0000 with no flag.
REQ-014 Simultaneous step_rise and mode change in a wait state: the mode change SHALL win and the step SHALL be dropped.
REQ-015 A mode change during S_IN_WR, S_CHK_RD or S_CHK_CAP SHALL be deferred until the access completes. It SHALL take effect from the following wait state and SHALL never truncate a strobe.
REQ-016 mem_we and mem_re SHALL never be high together. Both SHALL be 0 in S_IDLE and S_RUN.
REQ-017 busy SHALL be 1 exactly in S_IN_WR, S_CHK_RD and S_CHK_CAP.
REQ-018 In S_RUN, ld_addr, ld_data and check_data SHALL hold their values. step SHALL be ignored.
REQ-019 Leaving S_RUN SHALL drop cpustate from 11 on the next edge, so that the control unit's internal reset asserts.

Reset
REQ-020 While rst=0, the block SHALL hold: state S_IDLE, cpustate=00, ld_addr=0x0000, ld_data=0x00, check_data=0x00, mem_we=0, mem_re=0, busy=0, step_q=0.
REQ-021 Reset SHALL take effect immediately, including mid-access; an in-flight strobe SHALL deassert asynchronously.
REQ-022 After rst rises, the FSM SHALL evaluate mode_req on the first clk edge.

Verification
REQ-023 Load: mode_req=01, sw_data=0x15 then 0x2C, two step pulses -> mem_we pulses at ld_addr 0x0000 with data 0x15, then 0x0001 with data 0x2C; ld_addr ends at 0x0002.
REQ-024 Check: mode_req=10, memory[0]=0x15, one step pulse -> mem_re at 0x0000; check_data=0x15 three cycles after step_rise; ld_addr=0x0001.
REQ-025 Held step: step held high 20 cycles in IN mode -> exactly one mem_we.
REQ-026 Deferred mode: mode_req 01->11 during S_IN_WR -> mem_we completes its single cycle; cpustate=11 two edges later; mem_we=0 thereafter.
REQ-027 Wrap and reset: force ld_addr=0xFFFF in IN mode, then step -> write at 0xFFFF, ld_addr=0x0000. Assert rst=0 during S_CHK_RD -> mem_re drops at once; all outputs take their REQ-020 values.
